syscall_unit: RTL and testbench
===============================

Name: syscall_unit

Overview:
- Consumes syscall requests raised by the single-cycle datapath (syscall strobe plus $v0/$a0 values) and turns them into a byte stream for a console sink.
- Stalls the datapath while the request is serviced.
- Reads string bytes through a request/valid data-memory read port.
- Handles integer print, string print and exit. It replaces simulation-only prints with synthesizable behaviour.

Parameters:
MAX_STR_LEN, 256, maximum bytes emitted per print-string call; the string is truncated beyond this.
ADDR_W, 32, memory address width.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
syscall  in  1  high while the current instruction is SYSCALL
v0  in  32  syscall code ($v0)
a0  in  32  argument ($a0)
stall  out  1  hold PC/register writes
halted  out  1  sticky; set by exit
unknown_code  out  1  one-cycle pulse on an unsupported code
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  word-aligned read address
mem_rdata  in  32  read data
mem_valid  in  1  read data valid (any latency ≥1 cycle)
out_valid  out  1  output byte valid
out_data  out  8  ASCII byte
out_ready  in  1  sink accepts the byte

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; every output is 0; halted cleared.
  - Any in-flight print is abandoned with no partial-byte completion.
- stall is combinational:
  - stall = (state==IDLE & syscall & !halted) | (state not in {IDLE, DONE}).
- IDLE: when syscall=1, capture v0/a0 and dispatch on the next edge:
  - v0=1 → INT_SIGN.
  - v0=4 → STR_REQ.
  - v0=10 → HALT.
  - Any other value → pulse unknown_code and go to DONE.
- INT_SIGN:
  - If a0[31]=1, emit '-' (0x2D) and set rem = two's-complement negate of a0, taken as 32-bit unsigned. 0x80000000 therefore yields 2147483648.
  - Otherwise rem = a0. Then set pidx=9 and enter INT_DIV.
- INT_DIV: one compare/subtract per cycle against POW10[pidx].
  - If rem ≥ POW10[pidx]: rem -= POW10[pidx] and digit++.
  - Otherwise the digit is final. Emit '0'+digit if digit≠0, or if a digit has already been emitted, or if pidx==0 (so a0=0 prints "0").
  - After the emit decision, clear digit and decrement pidx. After pidx 0 → DONE.
- Emission (shared EMIT substate):
  - out_valid=1 with out_data held stable until out_ready=1 on a clock edge; then return to the calling state.
  - out_ready held low stalls indefinitely.
- STR_REQ / STR_WAIT:
  - Drive mem_req=1 and mem_addr={addr[31:2],2'b00} until mem_valid=1.
  - Byte = mem_rdata[8*addr[1:0] +: 8] (little-endian lanes).
  - Byte 0x00 → DONE. Otherwise emit it, addr++, cnt++.
  - cnt==MAX_STR_LEN → DONE; otherwise STR_REQ.
  - Each byte issues its own read; no caching. Address wraps modulo 2^ADDR_W.
- DONE: one cycle with stall=0 so the PC advances past SYSCALL. syscall is ignored this cycle. Then IDLE.
- HALT: halted=1 and stall=1 permanently until reset. syscall is ignored.
- unknown_code pulses for exactly one cycle (the dispatch edge).

Optional Feature:
SYSCALL_CHAR_EN:
- When defined, code v0=11 emits a0[7:0] as a single byte, then DONE. This takes one emit, then the DONE cycle.
- When undefined, code 11 is treated as unknown (unknown_code pulse, no output).

Decomposition:
- Package syscall_pkg holds:
  - Codes SYS_PRINT_INT=1, SYS_PRINT_STR=4, SYS_EXIT=10, SYS_PRINT_CHAR=11.
  - The state enum.
  - The 10-entry 32-bit POW10 table (10^0..10^9).
  - Constants ASCII_ZERO=0x30 and ASCII_MINUS=0x2D.
- Sub-module int_to_ascii holds the rem/pidx/digit datapath and the leading-zero flag. Its interface is start, digit_valid/digit_ready and done; the top-level FSM owns memory, emission and stall.

Test Plan:
- Print integer 1234: v0=1, a0=1234, out_ready=1 → bytes 0x31 0x32 0x33 0x34 in order. stall stays high until DONE, then drops for exactly one cycle.
- Negative extremes:
  - a0=0xFFFFFFFF → "-1".
  - a0=0x80000000 → "-2147483648" (11 bytes).
  - a0=0 → "0".
- Print string: memory at 0x1001 holds "Hi\0" in an unaligned word, mem_valid 3 cycles after mem_req → bytes 0x48 0x69. mem_addr=0x1000 for all reads. Three read requests total.
- Back-pressure: out_ready low for 20 cycles mid-string → out_data stable, out_valid high, no extra memory requests, no byte lost or duplicated.
- Exit and unknown:
  - v0=7 → unknown_code pulses one cycle and there is no output.
  - v0=10 → halted=1, stall=1. A later syscall is ignored. reset=0 asynchronously clears halted and stall.
- Truncation: MAX_STR_LEN=4 with an 8-char string → exactly 4 bytes, then DONE. With SYSCALL_CHAR_EN defined, v0=11, a0=0x141 → single byte 0x41.

Source files
------------

// File: rtl/syscall_pkg.sv
// syscall_pkg: shared definitions for the syscall unit.
//   - syscall codes understood by the unit ($v0 values)
//   - FSM state encoding for the top-level controller
//   - powers-of-ten table used by the integer-to-ASCII datapath
//   - ASCII constants for digits and the minus sign
package syscall_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INT_SIGN,
    S_INT_DIV,
    S_EMIT,
    S_STR_REQ,
    S_STR_WAIT,
    S_DONE,
    S_HALT
  } state_t;

  // 10^idx for idx = 0..9; anything larger never gets asked for.
  function automatic logic [31:0] pow10(input logic [3:0] idx);
    case (idx)
      4'd0:    pow10 = 32'd1;
      4'd1:    pow10 = 32'd10;
      4'd2:    pow10 = 32'd100;
      4'd3:    pow10 = 32'd1000;
      4'd4:    pow10 = 32'd10000;
      4'd5:    pow10 = 32'd100000;
      4'd6:    pow10 = 32'd1000000;
      4'd7:    pow10 = 32'd10000000;
      4'd8:    pow10 = 32'd100000000;
      4'd9:    pow10 = 32'd1000000000;
      default: pow10 = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/syscall_if.sv
// syscall_if: bundle of everything the syscall unit exchanges with the
// outside world.
//   datapath side : syscall, v0, a0 (in); stall, halted, unknown_code (out)
//   memory port   : mem_req, mem_addr (out); mem_rdata, mem_valid (in)
//   console sink  : out_valid, out_data (out); out_ready (in)
// Modport "slave" is the syscall unit, "master" is its environment.
interface syscall_if #(
  parameter int ADDR_W = 32
) ();

  logic              syscall;
  logic [31:0]       v0;
  logic [31:0]       a0;
  logic              stall;
  logic              halted;
  logic              unknown_code;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_valid;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;

  modport master (
    output syscall, v0, a0, mem_rdata, mem_valid, out_ready,
    input  stall, halted, unknown_code, mem_req, mem_addr, out_valid, out_data
  );

  modport slave (
    input  syscall, v0, a0, mem_rdata, mem_valid, out_ready,
    output stall, halted, unknown_code, mem_req, mem_addr, out_valid, out_data
  );

endinterface

// File: rtl/int_to_ascii.sv
// int_to_ascii: converts an unsigned 32-bit magnitude into decimal ASCII
// digits, most significant first, with leading zeros suppressed.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_start, i_value : load a new magnitude (one-cycle pulse)
//   o_digit_valid,
//   o_digit          : next ASCII digit, held until i_digit_ready
//   i_digit_ready    : consumer takes the digit this edge
//   o_done           : level, set once the units digit has been taken
module int_to_ascii
  import syscall_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_value,
  output logic        o_digit_valid,
  output logic [7:0]  o_digit,
  input  logic        i_digit_ready,
  output logic        o_done
);

  logic [31:0] r_rem;
  logic [3:0]  r_pidx;
  logic [3:0]  r_digit;
  logic        r_seen;
  logic        r_busy;
  logic        r_done;

  logic [31:0] w_pow;
  logic        w_ge;
  logic        w_emit;

  // A digit is final once the remainder drops below the current power;
  // it is shown unless it is a leading zero (units position always shows).
  assign w_pow  = pow10(r_pidx);
  assign w_ge   = (r_rem >= w_pow);
  assign w_emit = !w_ge && ((r_digit != 4'd0) || r_seen || (r_pidx == 4'd0));

  assign o_digit_valid = r_busy && w_emit;
  assign o_digit       = ASCII_ZERO + {4'b0000, r_digit};
  assign o_done        = r_done;

  // One compare/subtract per cycle; a suppressed digit advances at once,
  // a shown digit waits for the consumer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem   <= '0;
      r_pidx  <= '0;
      r_digit <= '0;
      r_seen  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_start) begin
      r_rem   <= i_value;
      r_pidx  <= 4'd9;
      r_digit <= '0;
      r_seen  <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_busy) begin
      if (w_ge) begin
        r_rem   <= r_rem - w_pow;
        r_digit <= r_digit + 4'd1;
      end else if (!w_emit || i_digit_ready) begin
        r_digit <= '0;
        r_seen  <= r_seen | w_emit;
        if (r_pidx == 4'd0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_pidx <= r_pidx - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/syscall_unit.sv
// syscall_unit: services SYSCALL requests from a single-cycle datapath and
// turns them into a console byte stream (print int, print string, exit).
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : syscall_if.slave (datapath request/stall, memory read
//                    port, console output stream)
// Parameters: MAX_STR_LEN (bytes per print-string, truncated beyond),
//             ADDR_W (memory address width).
// Build option: define SYSCALL_CHAR_EN to support print-char (code 11);
// without it code 11 is reported as unknown.
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int MAX_STR_LEN = 256,
  parameter int ADDR_W      = 32
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  syscall_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_STR_LEN + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STR_LEN);

  state_t            r_state,    w_nextState;
  state_t            r_retState, w_nextRet;
  logic [7:0]        r_emitByte, w_nextEmitByte;
  logic [ADDR_W-1:0] r_addr,     w_nextAddr;
  logic [CNT_W-1:0]  r_cnt,      w_nextCnt;
  logic [31:0]       r_arg,      w_nextArg;
  logic              r_unknown,  w_nextUnknown;

  logic        w_start;
  logic [31:0] w_magnitude;
  logic        w_digitValid;
  logic        w_digitReady;
  logic [7:0]  w_digitChar;
  logic        w_intDone;
  logic [7:0]  w_memByte;
  logic        w_halted;

  int_to_ascii u_int_to_ascii (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (w_start),
    .i_value       (w_magnitude),
    .o_digit_valid (w_digitValid),
    .o_digit       (w_digitChar),
    .i_digit_ready (w_digitReady),
    .o_done        (w_intDone)
  );

  // Negation wraps, so 0x80000000 comes out as 2147483648 unsigned.
  assign w_magnitude = r_arg[31] ? (~r_arg + 32'd1) : r_arg;
  assign w_memByte   = bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_halted    = (r_state == S_HALT);

  assign bus.stall        = ((r_state == S_IDLE) && bus.syscall && !w_halted) ||
                            ((r_state != S_IDLE) && (r_state != S_DONE));
  assign bus.halted       = w_halted;
  assign bus.unknown_code = r_unknown;
  assign bus.mem_req      = (r_state == S_STR_REQ) || (r_state == S_STR_WAIT);
  assign bus.mem_addr     = {r_addr[ADDR_W-1:2], 2'b00};
  assign bus.out_valid    = (r_state == S_EMIT);
  assign bus.out_data     = (r_state == S_EMIT) ? r_emitByte : 8'h00;

  // State and datapath registers; reset abandons whatever was in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_retState <= S_IDLE;
      r_emitByte <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_arg      <= '0;
      r_unknown  <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_retState <= w_nextRet;
      r_emitByte <= w_nextEmitByte;
      r_addr     <= w_nextAddr;
      r_cnt      <= w_nextCnt;
      r_arg      <= w_nextArg;
      r_unknown  <= w_nextUnknown;
    end
  end

  // Next-state logic. Every byte goes through S_EMIT, which returns to
  // r_retState once the sink accepts it.
  always_comb begin
    w_nextState    = r_state;
    w_nextRet      = r_retState;
    w_nextEmitByte = r_emitByte;
    w_nextAddr     = r_addr;
    w_nextCnt      = r_cnt;
    w_nextArg      = r_arg;
    w_nextUnknown  = 1'b0;
    w_start        = 1'b0;
    w_digitReady   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.syscall) begin
          w_nextArg  = bus.a0;
          w_nextAddr = bus.a0[ADDR_W-1:0];
          w_nextCnt  = '0;
          case (bus.v0)
            SYS_PRINT_INT: w_nextState = S_INT_SIGN;
            SYS_PRINT_STR: w_nextState = S_STR_REQ;
            SYS_EXIT:      w_nextState = S_HALT;
`ifdef SYSCALL_CHAR_EN
            SYS_PRINT_CHAR: begin
              w_nextEmitByte = bus.a0[7:0];
              w_nextRet      = S_DONE;
              w_nextState    = S_EMIT;
            end
`endif
            default: begin
              w_nextUnknown = 1'b1;
              w_nextState   = S_DONE;
            end
          endcase
        end
      end

      S_INT_SIGN: begin
        w_start = 1'b1;
        if (r_arg[31]) begin
          w_nextEmitByte = ASCII_MINUS;
          w_nextRet      = S_INT_DIV;
          w_nextState    = S_EMIT;
        end else begin
          w_nextState = S_INT_DIV;
        end
      end

      S_INT_DIV: begin
        if (w_digitValid) begin
          w_digitReady   = 1'b1;
          w_nextEmitByte = w_digitChar;
          w_nextRet      = S_INT_DIV;
          w_nextState    = S_EMIT;
        end else if (w_intDone) begin
          w_nextState = S_DONE;
        end
      end

      S_EMIT: begin
        if (bus.out_ready) w_nextState = r_retState;
      end

      S_STR_REQ: w_nextState = S_STR_WAIT;

      S_STR_WAIT: begin
        if (bus.mem_valid) begin
          if (w_memByte == 8'h00) begin
            w_nextState = S_DONE;
          end else begin
            w_nextEmitByte = w_memByte;
            w_nextAddr     = r_addr + 1'b1;
            w_nextCnt      = r_cnt + 1'b1;
            w_nextRet      = (w_nextCnt == MAX_CNT) ? S_DONE : S_STR_REQ;
            w_nextState    = S_EMIT;
          end
        end
      end

      S_DONE:  w_nextState = S_IDLE;
      S_HALT:  w_nextState = S_HALT;
      default: w_nextState = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: directed self-checking bench for syscall_unit
// (built with MAX_STR_LEN=4 so truncation is reachable with short strings).
module tb_syscall_unit;

  logic clk = 1'b0;
  logic rstN;

  always #5 clk = ~clk;

  syscall_if #(.ADDR_W(32)) sys ();

  syscall_unit #(.MAX_STR_LEN(4), .ADDR_W(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (sys)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Memory model state
  int          reqCount;
  logic [31:0] reqAddrs[$];
  logic [31:0] reqAddr;
  bit          memBusy;
  int          memLat;

  // Output monitor state
  logic [7:0]  rxBytes[$];
  int          unknownCount;
  bit          holdCheck;
  bit          holdSeen;
  bit          holdChanged;
  logic [7:0]  holdByte;

  // Counts every comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compares the captured byte stream against an expected string.
  task automatic checkBytes(input string tag, input string exp);
    checkOutput({tag, " length"}, rxBytes.size(), exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      checkOutput($sformatf("%s byte%0d", tag, i),
                  (i < rxBytes.size()) ? {24'h0, rxBytes[i]} : 32'hFFFF_FFFF,
                  {24'h0, exp[i]});
    end
  endtask

  // Word-organised test memory, little-endian byte lanes.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h1000: memWord = 32'h0069_4858;  // 'X' 'H' 'i' 0
      32'h2000: memWord = 32'h4443_4241;  // "ABCD"
      32'h2004: memWord = 32'h4847_4645;  // "EFGH"
      32'h3000: memWord = 32'h007A_7978;  // "xyz" 0
      default:  memWord = 32'h0000_0000;
    endcase
  endfunction

  // Read port answers three cycles after a request is first seen.
  always @(negedge clk) begin
    if (!rstN) begin
      memBusy       = 1'b0;
      sys.mem_valid = 1'b0;
    end else if (sys.mem_valid) begin
      sys.mem_valid = 1'b0;
      memBusy       = 1'b0;
    end else if (memBusy) begin
      memLat++;
      if (memLat == 3) begin
        sys.mem_valid = 1'b1;
        sys.mem_rdata = memWord(reqAddr);
      end
    end else if (sys.mem_req) begin
      memBusy = 1'b1;
      memLat  = 0;
      reqAddr = sys.mem_addr;
      reqCount++;
      reqAddrs.push_back(sys.mem_addr);
    end
  end

  // Captures accepted bytes, unknown-code pulses and hold stability.
  always @(negedge clk) begin
    if (rstN) begin
      if (sys.out_valid && sys.out_ready) rxBytes.push_back(sys.out_data);
      if (sys.unknown_code) unknownCount++;
      if (holdCheck && sys.out_valid) begin
        if (!holdSeen) begin
          holdSeen = 1'b1;
          holdByte = sys.out_data;
        end else if (sys.out_data !== holdByte) begin
          holdChanged = 1'b1;
        end
      end
    end
  end

  task automatic clearCapture();
    rxBytes.delete();
    reqAddrs.delete();
    reqCount     = 0;
    unknownCount = 0;
  endtask

  // Raises syscall and waits (bounded) for the DONE cycle where stall drops.
  task automatic applyStimulus(input string tag, input logic [31:0] code,
                               input logic [31:0] arg);
    int cycles;
    bit finished;
    clearCapture();
    @(posedge clk); #1;
    sys.syscall = 1'b1;
    sys.v0      = code;
    sys.a0      = arg;
    cycles   = 0;
    finished = 1'b0;
    while (!finished && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (sys.stall == 1'b0) finished = 1'b1;
    end
    checkOutput({tag, " completes"}, finished, 1'b1);
    @(posedge clk); #1;
    sys.syscall = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cycles;
    bit finished;

    sys.syscall   = 1'b0;
    sys.v0        = '0;
    sys.a0        = '0;
    sys.out_ready = 1'b1;
    sys.mem_valid = 1'b0;
    sys.mem_rdata = '0;
    holdCheck     = 1'b0;
    clearCapture();

    rstN = 1'b0;
    #12;
    checkOutput("reset stall",     sys.stall,        1'b0);
    checkOutput("reset halted",    sys.halted,       1'b0);
    checkOutput("reset unknown",   sys.unknown_code, 1'b0);
    checkOutput("reset mem_req",   sys.mem_req,      1'b0);
    checkOutput("reset out_valid", sys.out_valid,    1'b0);
    checkOutput("reset out_data",  sys.out_data,     8'h00);
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus("int1234", 32'd1, 32'd1234);
    checkBytes("int1234", "1234");
    checkOutput("int1234 no unknown", unknownCount, 0);
    checkOutput("int1234 no reads",   reqCount,     0);

    applyStimulus("intMinus1", 32'd1, 32'hFFFF_FFFF);
    checkBytes("intMinus1", "-1");

    applyStimulus("intMin", 32'd1, 32'h8000_0000);
    checkBytes("intMin", "-2147483648");

    applyStimulus("intZero", 32'd1, 32'd0);
    checkBytes("intZero", "0");

    applyStimulus("strHi", 32'd4, 32'h0000_1001);
    checkBytes("strHi", "Hi");
    checkOutput("strHi reads", reqCount, 3);
    foreach (reqAddrs[i]) checkOutput($sformatf("strHi addr%0d", i), reqAddrs[i], 32'h1000);

    // Back-pressure: hold the sink off after the first byte of "xyz".
    clearCapture();
    holdSeen    = 1'b0;
    holdChanged = 1'b0;
    @(posedge clk); #1;
    sys.syscall = 1'b1;
    sys.v0      = 32'd4;
    sys.a0      = 32'h3000;
    cycles   = 0;
    finished = 1'b0;
    while (!finished && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (rxBytes.size() == 1) finished = 1'b1;
    end
    checkOutput("bp first byte", finished, 1'b1);
    @(posedge clk); #1;
    sys.out_ready = 1'b0;
    holdCheck     = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("bp out_valid held", sys.out_valid, 1'b1);
    checkOutput("bp out_data held",  sys.out_data,  8'h79);
    checkOutput("bp data stable",    holdChanged,   1'b0);
    checkOutput("bp no extra reads", reqCount,      2);
    checkOutput("bp nothing taken",  rxBytes.size(), 1);
    checkOutput("bp stall",          sys.stall,     1'b1);
    holdCheck = 1'b0;
    @(posedge clk); #1;
    sys.out_ready = 1'b1;
    cycles   = 0;
    finished = 1'b0;
    while (!finished && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (sys.stall == 1'b0) finished = 1'b1;
    end
    checkOutput("bp completes", finished, 1'b1);
    @(posedge clk); #1;
    sys.syscall = 1'b0;
    @(negedge clk);
    checkBytes("bp", "xyz");
    checkOutput("bp reads", reqCount, 4);

    applyStimulus("unknown7", 32'd7, 32'd0);
    checkOutput("unknown7 pulse", unknownCount,   1);
    checkOutput("unknown7 bytes", rxBytes.size(), 0);
    checkOutput("unknown7 reads", reqCount,       0);

    applyStimulus("char", 32'd11, 32'h0000_0141);
`ifdef SYSCALL_CHAR_EN
    checkBytes("char", "A");
    checkOutput("char no unknown", unknownCount, 0);
`else
    checkOutput("char unknown pulse", unknownCount,   1);
    checkOutput("char bytes",         rxBytes.size(), 0);
`endif

    applyStimulus("trunc", 32'd4, 32'h0000_2000);
    checkBytes("trunc", "ABCD");
    checkOutput("trunc reads", reqCount, 4);

    // Exit: sticky halt, later syscalls ignored, async reset clears it.
    clearCapture();
    @(posedge clk); #1;
    sys.syscall = 1'b1;
    sys.v0      = 32'd10;
    sys.a0      = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("halt halted", sys.halted, 1'b1);
    checkOutput("halt stall",  sys.stall,  1'b1);
    @(posedge clk); #1;
    sys.v0 = 32'd1;
    sys.a0 = 32'd5;
    repeat (10) @(negedge clk);
    checkOutput("halt ignores syscall", rxBytes.size(), 0);
    checkOutput("halt out_valid",       sys.out_valid,  1'b0);
    checkOutput("halt still halted",    sys.halted,     1'b1);
    checkOutput("halt still stalled",   sys.stall,      1'b1);
    @(posedge clk); #1;
    sys.syscall = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async reset halted", sys.halted, 1'b0);
    checkOutput("async reset stall",  sys.stall,  1'b0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
